// File: rtl/datapath_sequencer.sv
// Micro-sequencer that stores a short program of datapath control words and
// replays one word per clock after a start pulse, driving the register-file/ALU datapath.
module datapath_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [9:0]    load_instr,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          wr,
  output logic [2:0]    aluControl,
  output logic [1:0]    addr1,
  output logic [1:0]    addr2,
  output logic [1:0]    addr3
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [9:0]    ctrl_q, ctrl_d;
  logic [9:0]    mem [DEPTH];

  logic [AW:0]   len_clamped;
  logic [AW-1:0] pc_inc;
  logic          last_step;

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (load_en && state_q == S_IDLE) begin
      mem[load_addr] <= load_instr;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    pc_inc      = pc_q + 1'b1;
    last_step   = ({1'b0, pc_q} == (len_q - 1'b1));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            pc_d    = '0;
            ctrl_d  = mem[0];
          end
        end
      end
      S_RUN: begin
        if (!hold) begin
          if (last_step) begin
            state_d = S_DONE;
            ctrl_d  = '0;
          end else begin
            pc_d   = pc_inc;
            ctrl_d = mem[pc_inc];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // wr is the only combinational output so a hold can cancel the write in the same cycle.
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pc         = pc_q;
  assign wr         = busy & ctrl_q[9] & ~hold;
  assign aluControl = ctrl_q[8:6];
  assign addr1      = ctrl_q[5:4];
  assign addr2      = ctrl_q[3:2];
  assign addr3      = ctrl_q[1:0];

endmodule
